// File: rtl/vco_spi_pkg.sv
// Shared constants and types for the VCO DAC SPI link.
// Used by VCO_ctrl (master side) and vco_spi_rx (receiver side).
package vco_spi_pkg;

    typedef enum logic {IDLE, RECV} rx_state_t;

    localparam int VCO_FRAME_W  = 16;
    localparam int VCO_CODE_W   = 12;
    localparam int VCO_CODE_LSB = 4;

endpackage

// File: rtl/vco_spi_rx_sync_bit.sv
// sync_bit: STAGES-deep flop chain bringing one async bit into clk.
// Ports: clk, arst (async, active-high), d (async in), q (synced out).
module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic arst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/vco_spi_rx.sv
// vco_spi_rx: oversampling SPI slave receiver for the VCO DAC link.
// Ports: clk, arst; sck/mosi/csn/clrn (async pins);
//   rdat, rx_valid, frame_err, dac_code, frame_cnt (registered outputs).
module vco_spi_rx
    import vco_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = VCO_FRAME_W,
    parameter int CODE_WIDTH  = VCO_CODE_W,
    parameter int CODE_LSB    = VCO_CODE_LSB,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  sck,
    input  logic                  mosi,
    input  logic                  csn,
    input  logic                  clrn,
    output logic [DATA_WIDTH-1:0] rdat,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic [CODE_WIDTH-1:0] dac_code,
    output logic [15:0]           frame_cnt
);

    // Wide enough to saturate one past a full frame.
    localparam int CW = $clog2(DATA_WIDTH + 2);

    logic sck_s, mosi_s, csn_s, clrn_s;
    logic sck_d, csn_d;
    logic sck_rise, csn_rise, csn_fall;

    rx_state_t state, state_n;
    logic      start, shift, done_ok, done_err;

    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         bitcnt;
    logic [15:0]           cnt_q;
    logic [15:0]           cnt_d;

    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .arst(arst), .d(sck), .q(sck_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .arst(arst), .d(mosi), .q(mosi_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn (
        .clk(clk), .arst(arst), .d(csn), .q(csn_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clrn (
        .clk(clk), .arst(arst), .d(clrn), .q(clrn_s)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sck_d <= 1'b0;
            csn_d <= 1'b1;
        end else begin
            sck_d <= sck_s;
            csn_d <= csn_s;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign csn_rise = csn_s & ~csn_d;
    assign csn_fall = ~csn_s & csn_d;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A csn rise takes priority over a coincident sck rise,
    // so that last bit is dropped.
    always_comb begin
        state_n  = state;
        start    = 1'b0;
        shift    = 1'b0;
        done_ok  = 1'b0;
        done_err = 1'b0;
        case (state)
            IDLE: begin
                if (csn_fall) begin
                    start   = 1'b1;
                    state_n = RECV;
                end
            end
            RECV: begin
                if (csn_rise) begin
                    state_n = IDLE;
                    if (bitcnt == CW'(DATA_WIDTH)) begin
                        done_ok = 1'b1;
                    end else begin
                        done_err = 1'b1;
                    end
                end else if (sck_rise && !csn_s) begin
                    shift = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Counter next value kept as a separate continuous signal.
    assign cnt_d = done_ok ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            shreg     <= '0;
            bitcnt    <= '0;
            rdat      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            dac_code  <= '0;
            cnt_q     <= '0;
        end else begin
            rx_valid  <= done_ok;
            frame_err <= done_err;
            cnt_q     <= cnt_d;
            if (start) begin
                shreg  <= '0;
                bitcnt <= '0;
            end else if (shift) begin
                shreg <= {shreg[DATA_WIDTH-2:0], mosi_s};
                if (bitcnt != CW'(DATA_WIDTH + 1)) begin
                    bitcnt <= bitcnt + CW'(1);
                end
            end
            if (done_ok) begin
                rdat <= shreg;
            end
            // Clear dominates; release leaves the code at 0.
            if (!clrn_s) begin
                dac_code <= '0;
            end else if (done_ok) begin
                dac_code <= shreg[CODE_LSB +: CODE_WIDTH];
            end
        end
    end

    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_vco_spi_rx.sv
// Directed self-checking bench for vco_spi_rx.
// Drives SPI frames at sck = clk/8 and checks outputs after each frame.
module tb_vco_spi_rx;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        csn = 1'b1;
    logic        clrn = 1'b1;
    logic [15:0] rdat;
    logic        rx_valid;
    logic        frame_err;
    logic [11:0] dac_code;
    logic [15:0] frame_cnt;

    int nvec = 0;
    int nerr = 0;
    int nv, ne, nb;

    always #5 clk = ~clk;

    vco_spi_rx dut (
        .clk(clk), .arst(arst), .sck(sck), .mosi(mosi), .csn(csn),
        .clrn(clrn), .rdat(rdat), .rx_valid(rx_valid),
        .frame_err(frame_err), .dac_code(dac_code), .frame_cnt(frame_cnt)
    );

    task automatic send_bits(input logic [31:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = data[i];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    // Observe pulses in a bounded window after csn rises.
    task automatic watch(output int v, output int e, output int b);
        v = 0; e = 0; b = 0;
        repeat (12) begin
            @(negedge clk);
            if (rx_valid) v++;
            if (frame_err) e++;
            if (rx_valid && frame_err) b++;
        end
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits,
                              output int v, output int e, output int b);
        csn = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(data, nbits);
        repeat (4) @(negedge clk);
        csn = 1'b1;
        mosi = 1'b0;
        watch(v, e, b);
    endtask

    task automatic test_reset;
        arst = 1'b1;
        repeat (3) @(negedge clk);
        nvec++; if (rdat !== 16'h0) begin $display("FAIL reset_rdat got %h want 0000", rdat); nerr++; end
        nvec++; if (dac_code !== 12'h0) begin $display("FAIL reset_dac got %h want 000", dac_code); nerr++; end
        nvec++; if (frame_cnt !== 16'h0) begin $display("FAIL reset_cnt got %h want 0000", frame_cnt); nerr++; end
        nvec++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            $display("FAIL reset_pulses got v=%b e=%b want 0 0", rx_valid, frame_err); nerr++; end
        arst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_good;
        send_frame(32'h4000, 16, nv, ne, nb);
        nvec++; if (nv !== 1 || ne !== 0 || nb !== 0) begin
            $display("FAIL good_pulses got v=%0d e=%0d both=%0d want 1 0 0", nv, ne, nb); nerr++; end
        nvec++; if (rdat !== 16'h4000) begin $display("FAIL good_rdat got %h want 4000", rdat); nerr++; end
        nvec++; if (dac_code !== 12'h400) begin $display("FAIL good_dac got %h want 400", dac_code); nerr++; end
        nvec++; if (frame_cnt !== 16'd1) begin $display("FAIL good_cnt got %0d want 1", frame_cnt); nerr++; end
    endtask

    task automatic test_short;
        send_frame(32'h1234, 15, nv, ne, nb);
        nvec++; if (nv !== 0 || ne !== 1) begin
            $display("FAIL short_pulses got v=%0d e=%0d want 0 1", nv, ne); nerr++; end
        nvec++; if (rdat !== 16'h4000 || dac_code !== 12'h400 || frame_cnt !== 16'd1) begin
            $display("FAIL short_hold got %h %h %0d want 4000 400 1", rdat, dac_code, frame_cnt); nerr++; end
    endtask

    task automatic test_long;
        send_frame(32'h1ABCD, 17, nv, ne, nb);
        nvec++; if (nv !== 0 || ne !== 1) begin
            $display("FAIL long_pulses got v=%0d e=%0d want 0 1", nv, ne); nerr++; end
        nvec++; if (frame_cnt !== 16'd1) begin $display("FAIL long_cnt got %0d want 1", frame_cnt); nerr++; end
        send_frame(32'h0010, 16, nv, ne, nb);
        nvec++; if (nv !== 1 || ne !== 0) begin
            $display("FAIL after_long_pulses got v=%0d e=%0d want 1 0", nv, ne); nerr++; end
        nvec++; if (dac_code !== 12'h001 || rdat !== 16'h0010 || frame_cnt !== 16'd2) begin
            $display("FAIL after_long got %h %h %0d want 001 0010 2", dac_code, rdat, frame_cnt); nerr++; end
    endtask

    task automatic test_clrn;
        clrn = 1'b0;
        repeat (6) @(negedge clk);
        nvec++; if (dac_code !== 12'h0) begin $display("FAIL clrn_clear got %h want 000", dac_code); nerr++; end
        send_frame(32'h7E80, 16, nv, ne, nb);
        nvec++; if (nv !== 1 || rdat !== 16'h7E80 || frame_cnt !== 16'd3) begin
            $display("FAIL clrn_frame got v=%0d %h %0d want 1 7e80 3", nv, rdat, frame_cnt); nerr++; end
        nvec++; if (dac_code !== 12'h0) begin $display("FAIL clrn_dac got %h want 000", dac_code); nerr++; end
        clrn = 1'b1;
        repeat (6) @(negedge clk);
        nvec++; if (dac_code !== 12'h0) begin $display("FAIL clrn_release got %h want 000", dac_code); nerr++; end
        send_frame(32'h0800, 16, nv, ne, nb);
        nvec++; if (dac_code !== 12'h080 || frame_cnt !== 16'd4) begin
            $display("FAIL clrn_after got %h %0d want 080 4", dac_code, frame_cnt); nerr++; end
    endtask

    task automatic test_reset_mid;
        csn = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(32'hA5, 8);
        arst = 1'b1;
        repeat (2) @(negedge clk);
        nvec++; if (rdat !== 16'h0 || dac_code !== 12'h0 || frame_cnt !== 16'h0) begin
            $display("FAIL mid_reset got %h %h %h want 0 0 0", rdat, dac_code, frame_cnt); nerr++; end
        arst = 1'b0;
        repeat (8) @(negedge clk);
        csn = 1'b1;
        watch(nv, ne, nb);
        nvec++; if (nv !== 0 || ne !== 1) begin
            $display("FAIL mid_partial got v=%0d e=%0d want 0 1", nv, ne); nerr++; end
        send_frame(32'hFFF0, 16, nv, ne, nb);
        nvec++; if (dac_code !== 12'hFFF || frame_cnt !== 16'd1) begin
            $display("FAIL mid_next got %h %0d want fff 1", dac_code, frame_cnt); nerr++; end
    endtask

    // Tail of a VCO_ctrl ramp up to P1_MAX=1024, step 2, code in frame[15:4].
    task automatic test_ramp;
        logic [11:0] code;
        for (int i = 0; i < 6; i++) begin
            code = 12'(1014 + 2 * i);
            send_frame({16'h0, code, 4'h0}, 16, nv, ne, nb);
            nvec++; if (nv !== 1 || dac_code !== code) begin
                $display("FAIL ramp_%0d got v=%0d %h want 1 %h", i, nv, dac_code, code); nerr++; end
        end
    endtask

    task automatic test_wrap;
        force dut.cnt_d = 16'hFFFF;
        @(negedge clk);
        release dut.cnt_d;
        repeat (2) @(negedge clk);
        nvec++; if (frame_cnt !== 16'hFFFF) begin $display("FAIL wrap_preload got %h want ffff", frame_cnt); nerr++; end
        send_frame(32'h0020, 16, nv, ne, nb);
        nvec++; if (nv !== 1 || frame_cnt !== 16'h0 || dac_code !== 12'h002) begin
            $display("FAIL wrap got v=%0d %h %h want 1 0000 002", nv, frame_cnt, dac_code); nerr++; end
    endtask

    initial begin
        test_reset;
        test_good;
        test_short;
        test_long;
        test_clrn;
        test_reset_mid;
        test_ramp;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
